// File: rtl/proximity_filter.sv
// Moving-average distance filter with a debounced, hysteretic "object near" flag.
// Zero-distance samples are sensor timeouts and never enter the averaging window.
module proximity_filter #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2,
  parameter int NEAR_CM    = 20,
  parameter int FAR_CM     = 30,
  parameter int HOLD       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] distance_in,
  input  logic             distance_valid,
  output logic [WIDTH-1:0] avg_distance,
  output logic             avg_valid,
  output logic             object_near,
  output logic             near_change
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SUM_W = WIDTH + DEPTH_LOG2;
  localparam int CNT_W = $clog2(HOLD + 1);

  localparam logic [DEPTH_LOG2:0] DEPTH_C = DEPTH_LOG2'(1) << DEPTH_LOG2;
  localparam logic [WIDTH-1:0]    NEAR_C  = WIDTH'(NEAR_CM);
  localparam logic [WIDTH-1:0]    FAR_C   = WIDTH'(FAR_CM);
  localparam logic [CNT_W-1:0]    HOLD_C  = CNT_W'(HOLD);

  typedef enum logic {ST_FAR, ST_NEAR} state_t;

  // Strobe semantics: distance_valid and avg_valid are single-cycle strobes with
  // no back-pressure; every strobe is consumed on the clk edge where it is high.
  logic [WIDTH-1:0]      buf_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      sum_next;
  logic [DEPTH_LOG2:0]   fill;
  logic                  accept;
  logic                  window_full_next;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_inc;

  assign accept           = distance_valid && (distance_in != '0);
  assign window_full_next = (fill >= (DEPTH_C - 1'b1));
  assign cnt_inc          = cnt + 1'b1;

  // The slot being overwritten is still zero while the window fills, so the
  // same update works before and after the buffer wraps.
  always_comb begin
    sum_next = sum - {{DEPTH_LOG2{1'b0}}, buf_mem[wr_ptr]}
                   + {{DEPTH_LOG2{1'b0}}, distance_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
      wr_ptr       <= '0;
      sum          <= '0;
      fill         <= '0;
      avg_distance <= '0;
      avg_valid    <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (accept) begin
        buf_mem[wr_ptr] <= distance_in;
        wr_ptr          <= wr_ptr + 1'b1;
        sum             <= sum_next;
        if (fill != DEPTH_C) fill <= fill + 1'b1;
        if (window_full_next) begin
          avg_distance <= sum_next[SUM_W-1:DEPTH_LOG2];
          avg_valid    <= 1'b1;
        end
      end
    end
  end

  // Hysteresis: the thresholds are strict, and a state change needs HOLD
  // consecutive qualifying averages; any non-qualifying average restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FAR;
      cnt         <= '0;
      object_near <= 1'b0;
      near_change <= 1'b0;
    end else begin
      near_change <= 1'b0;
      if (avg_valid) begin
        case (state)
          ST_FAR: begin
            if (avg_distance < NEAR_C) begin
              if (cnt_inc == HOLD_C) begin
                state       <= ST_NEAR;
                cnt         <= '0;
                object_near <= 1'b1;
                near_change <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt <= '0;
            end
          end
          ST_NEAR: begin
            if (avg_distance > FAR_C) begin
              if (cnt_inc == HOLD_C) begin
                state       <= ST_FAR;
                cnt         <= '0;
                object_near <= 1'b0;
                near_change <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt <= '0;
            end
          end
          default: begin
            state <= ST_FAR;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_proximity_filter.sv
// Randomized and directed stimulus for proximity_filter, checked by a scoreboard
// fed from a window-of-samples reference model.
module tb_proximity_filter;

  localparam int W        = 8;
  localparam int DEPTH    = 4;
  localparam int NEAR_CM  = 20;
  localparam int FAR_CM   = 30;
  localparam int HOLD     = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] distance_in = '0;
  logic         distance_valid = 1'b0;
  logic [W-1:0] avg_distance;
  logic         avg_valid;
  logic         object_near;
  logic         near_change;

  proximity_filter dut (
    .clk            (clk),
    .rst            (rst),
    .distance_in    (distance_in),
    .distance_valid (distance_valid),
    .avg_distance   (avg_distance),
    .avg_valid      (avg_valid),
    .object_near    (object_near),
    .near_change    (near_change)
  );

  // clock / edge counter
  always #5 clk = ~clk;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic         chg_q[$];
  int           chg_cyc_q[$];
  int           checks = 0;
  int           errors = 0;

  // reference model state
  int   win[$];
  logic model_flag = 1'b0;
  int   model_hold = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: mean of the last DEPTH accepted samples, then a streak counter
  // over those means that flips the flag after HOLD qualifying means in a row.
  task automatic model_accept(input int d, input int e);
    int s;
    int a;
    logic qual;
    win.push_back(d);
    if (win.size() > DEPTH) void'(win.pop_front());
    if (win.size() == DEPTH) begin
      s = 0;
      foreach (win[i]) s += win[i];
      a = s / DEPTH;
      exp_q.push_back(a[W-1:0]);
      exp_cyc_q.push_back(e);
      qual = model_flag ? (a > FAR_CM) : (a < NEAR_CM);
      model_hold = qual ? model_hold + 1 : 0;
      if (model_hold == HOLD) begin
        model_flag = ~model_flag;
        model_hold = 0;
        chg_q.push_back(model_flag);
        chg_cyc_q.push_back(e + 1);
      end
    end
  endtask

  // driver tasks
  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    distance_valid = 1'b1;
    distance_in    = d;
    @(posedge clk); #1;
    distance_valid = 1'b0;
    distance_in    = W'($urandom);
    if (d != 0) model_accept(int'(d), edge_n);
  endtask

  task automatic do_reset(input logic with_sample);
    repeat (3) idle();
    rst            = 1'b1;
    distance_valid = with_sample;
    distance_in    = 8'd50;
    @(posedge clk); #1;
    rst            = 1'b0;
    distance_valid = 1'b0;
    win.delete();
    model_flag = 1'b0;
    model_hold = 0;
    @(negedge clk);
    check("reset_avg_distance", avg_distance, 0);
    check("reset_avg_valid",    avg_valid,    0);
    check("reset_object_near",  object_near,  0);
    check("reset_near_change",  near_change,  0);
    @(posedge clk); #1;
  endtask

  // monitor
  logic mon_flag = 1'b0;
  logic mon_e;
  int   mon_c;
  logic [W-1:0] mon_avg;

  always @(negedge clk) begin
    if (rst) begin
      mon_flag = 1'b0;
    end else begin
      if (near_change) begin
        if (chg_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL near_change_unexpected actual=1 expected=0 (t=%0t)", $time);
        end else begin
          mon_e = chg_q.pop_front();
          mon_c = chg_cyc_q.pop_front();
          check("near_change_cycle", edge_n, mon_c);
          check("object_near_on_change", object_near, mon_e);
          mon_flag = mon_e;
        end
      end else if (avg_valid) begin
        check("object_near_hold", object_near, mon_flag);
      end
      if (avg_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL avg_valid_unexpected actual=1 expected=0 avg=%0d (t=%0t)", avg_distance, $time);
        end else begin
          mon_avg = exp_q.pop_front();
          mon_c   = exp_cyc_q.pop_front();
          check("avg_distance", avg_distance, mon_avg);
          check("avg_valid_cycle", edge_n, mon_c);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [W-1:0] d;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    // fill: no strobe until the 4th sample
    repeat (4) send(8'd40);
    repeat (2) idle();

    // approach: averages 32,24,16,8 then one more 8 enters NEAR
    repeat (5) send(8'd8);
    repeat (3) idle();

    // leave NEAR with a streak broken by a non-qualifying average
    repeat (5) send(8'd35);
    send(8'd1);
    repeat (8) send(8'd35);
    repeat (3) idle();

    // timeouts interleaved with samples
    do_reset(1'b0);
    repeat (4) send(8'd40);
    for (int i = 0; i < 6; i++) begin
      send(8'd0);
      send(8'd40);
      if (i % 2 == 0) send(8'd0);
    end
    repeat (2) idle();

    // extreme values
    repeat (4) send(8'd255);
    repeat (4) send(8'd1);
    repeat (3) idle();

    // reset mid-window with a coincident strobe; old entries must not contribute
    do_reset(1'b0);
    send(8'd200);
    send(8'd200);
    do_reset(1'b1);
    repeat (3) send(8'd12);
    idle();
    send(8'd16);
    repeat (3) idle();

    // random traffic with gaps, timeouts and threshold crossings
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       d = 8'd0;
        1:       d = W'($urandom_range(200, 255));
        2, 3, 4: d = W'($urandom_range(1, 19));
        default: d = W'($urandom_range(15, 45));
      endcase
      send(d);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) idle();
    end

    repeat (5) idle();
    check("avg_queue_drained", exp_q.size(), 0);
    check("change_queue_drained", chg_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
